// File: rtl/hamming_transmisor_serie.sv
`default_nettype none
// ============================================================================
// Module   : hamming_transmisor_serie
// Purpose  : Transmit side of a Hamming SECDED link. Accepts a 4-bit word on
//            a valid/ready handshake and encodes it into an 8-bit SECDED
//            codeword. The codeword is registered and then sent as a
//            UART-style frame: start bit (0), 8 codeword bits LSB first,
//            stop bit (1). Each serial bit lasts CICLOS_BIT clock cycles.
// Ports    : clk             - system clock, rising edge
//            rst_n           - synchronous active-low reset
//            dato_i[3:0]     - data word {w3,w2,w1,w0}, sampled on transfer
//            valido_i        - dato_i valid
//            mascara_error_i - error-injection mask (INYECCION_ERROR_EN only)
//            listo_o         - ready to accept a word (idle)
//            palabra_o[7:0]  - codeword of the last accepted word
//            serie_o         - serial line, idles high
//            activo_o        - high while a frame is on the line
//            fin_o           - one-cycle pulse after a frame completes
// Macro    : INYECCION_ERROR_EN - adds mascara_error_i; the registered and
//            transmitted codeword is XORed with the mask at transfer.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_transmisor_serie #(
  parameter int CICLOS_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dato_i,
  input  logic       valido_i,
`ifdef INYECCION_ERROR_EN
  input  logic [7:0] mascara_error_i,
`endif
  output logic       listo_o,
  output logic [7:0] palabra_o,
  output logic       serie_o,
  output logic       activo_o,
  output logic       fin_o
);

  localparam int              c_ANCHO_CNT = (CICLOS_BIT > 1) ? $clog2(CICLOS_BIT) : 1;
  localparam logic [c_ANCHO_CNT-1:0] c_ULTIMO = c_ANCHO_CNT'(CICLOS_BIT - 1);

  localparam logic [1:0] c_REPOSO = 2'd0;
  localparam logic [1:0] c_INICIO = 2'd1;
  localparam logic [1:0] c_DATOS  = 2'd2;
  localparam logic [1:0] c_PARADA = 2'd3;

  logic [1:0]             estado_q,  estado_d;
  logic [c_ANCHO_CNT-1:0] cnt_q,     cnt_d;
  logic [2:0]             indice_q,  indice_d;
  logic [7:0]             palabra_q, palabra_d;
  logic                   serie_q,   serie_d;
  logic                   activo_q,  activo_d;
  logic                   listo_q,   listo_d;
  logic                   fin_q,     fin_d;

  logic [6:0] w_base;
  logic [7:0] w_codigo;
  logic [7:0] w_mascara;
  logic       w_fin_bit;

  // Codeword layout: {p8, w3, w2, w1, p4, w0, p2, p1}; p8 is overall parity.
  assign w_base = {dato_i[3], dato_i[2], dato_i[1],
                   dato_i[1] ^ dato_i[2] ^ dato_i[3],
                   dato_i[0],
                   dato_i[0] ^ dato_i[2] ^ dato_i[3],
                   dato_i[0] ^ dato_i[1] ^ dato_i[3]};
  assign w_codigo = {^w_base, w_base};

`ifdef INYECCION_ERROR_EN
  assign w_mascara = mascara_error_i;
`else
  assign w_mascara = 8'h00;
`endif

  assign w_fin_bit = (cnt_q == c_ULTIMO);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q  <= c_REPOSO;
      cnt_q     <= '0;
      indice_q  <= 3'd0;
      palabra_q <= 8'h00;
      serie_q   <= 1'b1;
      activo_q  <= 1'b0;
      listo_q   <= 1'b1;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      indice_q  <= indice_d;
      palabra_q <= palabra_d;
      serie_q   <= serie_d;
      activo_q  <= activo_d;
      listo_q   <= listo_d;
      fin_q     <= fin_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    indice_d  = indice_q;
    palabra_d = palabra_q;

    // Bit-period divider runs in every non-idle state and wraps per bit.
    if (estado_q != c_REPOSO) begin
      cnt_d = w_fin_bit ? '0 : cnt_q + 1'b1;
    end

    case (estado_q)
      c_REPOSO: begin
        if (valido_i) begin
          estado_d  = c_INICIO;
          palabra_d = w_codigo ^ w_mascara;
          cnt_d     = '0;
          indice_d  = 3'd0;
        end
      end
      c_INICIO: begin
        if (w_fin_bit) begin
          estado_d = c_DATOS;
          indice_d = 3'd0;
        end
      end
      c_DATOS: begin
        if (w_fin_bit) begin
          if (indice_q == 3'd7) begin
            estado_d = c_PARADA;
          end
          // Natural 3-bit wrap leaves the index at 0 for the next frame.
          indice_d = indice_q + 3'd1;
        end
      end
      c_PARADA: begin
        if (w_fin_bit) begin
          estado_d = c_REPOSO;
        end
      end
      default: begin
        estado_d = c_REPOSO;
      end
    endcase
  end

  // Output logic: computed from the next state so every output is a flop.
  always_comb begin
    serie_d  = 1'b1;
    activo_d = (estado_d != c_REPOSO);
    listo_d  = (estado_d == c_REPOSO);
    fin_d    = (estado_q == c_PARADA) && (estado_d == c_REPOSO);
    case (estado_d)
      c_INICIO: serie_d = 1'b0;
      c_DATOS:  serie_d = palabra_d[indice_d];
      default:  serie_d = 1'b1;
    endcase
  end

  assign listo_o   = listo_q;
  assign palabra_o = palabra_q;
  assign serie_o   = serie_q;
  assign activo_o  = activo_q;
  assign fin_o     = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_transmisor_serie.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_transmisor_serie
// Purpose  : Scoreboard bench for hamming_transmisor_serie. Two instances run
//            side by side (CICLOS_BIT=4 and CICLOS_BIT=1). Stimulus pushes
//            hand-computed codewords into per-instance queues; a monitor
//            captures each serial frame and checks it when fin_o pulses.
// Macro    : INYECCION_ERROR_EN - also connects and exercises the mask port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_transmisor_serie;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] dato4, dato1;
  logic       valido4, valido1;
  logic [1:0] listo_v, serie_v, activo_v, fin_v;
  logic [7:0] palabra4, palabra1;
`ifdef INYECCION_ERROR_EN
  logic [7:0] mascara4, mascara1;
`endif

  hamming_transmisor_serie #(.CICLOS_BIT(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .dato_i   (dato4),
    .valido_i (valido4),
`ifdef INYECCION_ERROR_EN
    .mascara_error_i (mascara4),
`endif
    .listo_o  (listo_v[0]),
    .palabra_o(palabra4),
    .serie_o  (serie_v[0]),
    .activo_o (activo_v[0]),
    .fin_o    (fin_v[0])
  );

  hamming_transmisor_serie #(.CICLOS_BIT(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .dato_i   (dato1),
    .valido_i (valido1),
`ifdef INYECCION_ERROR_EN
    .mascara_error_i (mascara1),
`endif
    .listo_o  (listo_v[1]),
    .palabra_o(palabra1),
    .serie_o  (serie_v[1]),
    .activo_o (activo_v[1]),
    .fin_o    (fin_v[1])
  );

  // Hand-computed codewords for dato = 0..15
  localparam logic [7:0] c_TABLA [16] = '{
    8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
    8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF
  };

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_exp4[$];
  logic [7:0] q_exp1[$];

  task automatic chk(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
    n_cmp++;
    if (actual !== esperado) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nombre, actual, esperado, $time);
    end
  endtask

  // Expected line samples for one frame: start, 8 bits LSB first, stop.
  function automatic logic [39:0] trama(input logic [7:0] w, input int cb);
    logic [39:0] t;
    t = '0;
    for (int i = 0; i < 10 * cb; i++) begin
      int b;
      b = i / cb;
      if (b == 0)      t[i] = 1'b0;
      else if (b == 9) t[i] = 1'b1;
      else             t[i] = w[b-1];
    end
    return t;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic [39:0] buf_v [2];
  int          len_v [2];
  bit          listo_mal [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      buf_v[k] = '0;
      len_v[k] = 0;
      listo_mal[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int         cb;
        int         n_pend;
        logic [7:0] pal;
        logic [7:0] esp;
        logic [39:0] mk;
        cb  = (k == 0) ? 4 : 1;
        mk  = (k == 0) ? 40'hFF_FFFF_FFFF : 40'h00_0000_03FF;
        pal = (k == 0) ? palabra4 : palabra1;
        n_pend = (k == 0) ? q_exp4.size() : q_exp1.size();
        if (!rst_n) begin
          len_v[k] = 0;
          listo_mal[k] = 1'b0;
        end else if (activo_v[k]) begin
          if (len_v[k] < 40) buf_v[k][len_v[k]] = serie_v[k];
          len_v[k]++;
          if (listo_v[k]) listo_mal[k] = 1'b1;
        end else if (fin_v[k]) begin
          chk($sformatf("trama_pendiente_en_fin%0d", k), (n_pend > 0), 1);
          if (n_pend > 0) begin
            if (k == 0) esp = q_exp4.pop_front();
            else        esp = q_exp1.pop_front();
            chk($sformatf("palabra%0d", k), pal, esp);
            chk($sformatf("paridad_par%0d", k), ^pal, 0);
            chk($sformatf("longitud_trama%0d", k), len_v[k], 10 * cb);
            chk($sformatf("bits_serie%0d", k), buf_v[k] & mk, trama(esp, cb));
            chk($sformatf("listo_bajo_en_trama%0d", k), listo_mal[k], 0);
            chk($sformatf("listo_en_fin%0d", k), listo_v[k], 1);
          end
          len_v[k] = 0;
          listo_mal[k] = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic enviar(input int k, input logic [3:0] d, input logic [7:0] m,
                        input logic [7:0] esp, input bit anotar);
    for (int c = 0; c < 300; c++) begin
      if (listo_v[k]) break;
      @(posedge clk);
      #1;
    end
    chk("espera_listo", listo_v[k], 1);
    if (k == 0) begin
      dato4 = d;
      valido4 = 1'b1;
`ifdef INYECCION_ERROR_EN
      mascara4 = m;
`endif
      if (anotar) q_exp4.push_back(esp);
    end else begin
      dato1 = d;
      valido1 = 1'b1;
`ifdef INYECCION_ERROR_EN
      mascara1 = m;
`endif
      if (anotar) q_exp1.push_back(esp);
    end
    @(posedge clk);
    #1;
    valido4 = 1'b0;
    valido1 = 1'b0;
`ifdef INYECCION_ERROR_EN
    // The mask must only matter on the transfer edge.
    mascara4 = 8'hFF;
    mascara1 = 8'hFF;
`else
    if (m != 8'h00) $display("note: mask ignored in this build");
`endif
  endtask

  task automatic esperar_vacio();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (q_exp4.size() == 0 && q_exp1.size() == 0) break;
    end
    chk("colas_vacias", q_exp4.size() + q_exp1.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    dato4 = 4'h0;
    dato1 = 4'h0;
    valido4 = 1'b0;
    valido1 = 1'b0;
`ifdef INYECCION_ERROR_EN
    mascara4 = 8'h00;
    mascara1 = 8'h00;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_serie",   serie_v,  2'b11);
    chk("rst_listo",   listo_v,  2'b11);
    chk("rst_activo",  activo_v, 2'b00);
    chk("rst_fin",     fin_v,    2'b00);
    chk("rst_palabra4", palabra4, 8'h00);
    chk("rst_palabra1", palabra1, 8'h00);

    // 40-cycle frame of E1 on the CICLOS_BIT=4 instance
    enviar(0, 4'b1100, 8'h00, 8'hE1, 1'b1);
    // Single-cycle bits, then the full encoding sweep back-to-back
    enviar(1, 4'b1100, 8'h00, 8'hE1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      enviar(1, 4'(i), 8'h00, c_TABLA[i], 1'b1);
    end

    // valido_i held high, dato_i changed mid-frame
    for (int c = 0; c < 300; c++) begin
      if (listo_v[0]) break;
      @(posedge clk);
      #1;
    end
    dato4 = 4'b0011;
    valido4 = 1'b1;
    q_exp4.push_back(8'h1E);
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    dato4 = 4'b1010;
    q_exp4.push_back(8'hD2);
    chk("palabra_retenida", palabra4, 8'h1E);
    chk("listo_en_trama", listo_v[0], 0);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (fin_v[0]) break;
    end
    chk("espera_fin", fin_v[0], 1);
    @(posedge clk);
    #1 valido4 = 1'b0;
    @(negedge clk);
    chk("b2b_activo", activo_v[0], 1);
    chk("b2b_palabra", palabra4, 8'hD2);
    esperar_vacio();

    // Reset during DATOS bit 3: frame aborted, no fin_o
    enviar(0, 4'b1100, 8'h00, 8'hE1, 1'b0);
    repeat (18) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_serie",   serie_v[0],  1);
    chk("abort_listo",   listo_v[0],  1);
    chk("abort_activo",  activo_v[0], 0);
    chk("abort_palabra", palabra4,    8'h00);
    chk("abort_fin",     fin_v[0],    0);
    repeat (45) @(negedge clk);

`ifdef INYECCION_ERROR_EN
    enviar(0, 4'b1100, 8'h04, 8'hE5, 1'b1);
    enviar(0, 4'b1100, 8'h60, 8'h81, 1'b1);
    enviar(1, 4'b1100, 8'h04, 8'hE5, 1'b1);
`endif

    // One more clean frame after the abort
    enviar(0, 4'b0001, 8'h00, 8'h87, 1'b1);
    esperar_vacio();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/hamming_transmisor_serie.md
Name: hamming_transmisor_serie

Overview:
- Transmit side of the Hamming SECDED link; its output is the 8-bit codeword the receiver/decoder checks.
- Accepts a 4-bit data word over a valid/ready handshake and encodes it into an 8-bit SECDED codeword.
- Registers the codeword and sends it as a UART-style serial frame: start bit, 8 codeword bits LSB first, stop bit.

Parameters:
- CICLOS_BIT, default 4: clock cycles each serial bit is held; legal range ≥1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- dato_i  input  4  data word {w3,w2,w1,w0}; sampled only on handshake.
- valido_i  input  1  dato_i valid.
- listo_o  output  1  ready to accept a word.
- palabra_o  output  8  registered codeword of the last accepted word.
- serie_o  output  1  serial line; idles high.
- activo_o  output  1  high while a frame is on the line.
- fin_o  output  1  one-cycle pulse when a frame completes.
- mascara_error_i  input  8  error-injection mask; present only with INYECCION_ERROR_EN.

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block.
- Reset values: state REPOSO, serie_o=1, listo_o=1, activo_o=0, fin_o=0, palabra_o=8'h00, all counters 0.
- Codeword bit layout:
  - bit0=p1=w0^w1^w3
  - bit1=p2=w0^w2^w3
  - bit2=w0
  - bit3=p4=w1^w2^w3
  - bit4=w1, bit5=w2, bit6=w3
  - bit7=XOR of bits 6..0 (overall even parity)
- Handshake: transfer occurs when valido_i && listo_o at a rising edge.
  - On that edge palabra_o loads the codeword and the state moves to INICIO.
  - listo_o is high only in REPOSO. valido_i is ignored in every other state; dato_i need not be held after the transfer.
- States:
  - REPOSO: serie_o=1, activo_o=0, listo_o=1. Transfer → INICIO.
  - INICIO: serie_o=0 for CICLOS_BIT cycles → DATOS, with bit index 0.
  - DATOS: serie_o=palabra_o[indice], held CICLOS_BIT cycles per bit; indice 0..7. After bit 7's last cycle → PARADA.
  - PARADA: serie_o=1 for CICLOS_BIT cycles → REPOSO.
- activo_o=1 in INICIO, DATOS and PARADA.
- A cycle divider counts 0..CICLOS_BIT-1 and wraps at the end of each bit.
  - CICLOS_BIT=1: every bit lasts exactly one cycle.
  - Counter width is max(1,$clog2(CICLOS_BIT)).
  - The bit index is 3 bits; wrap after 7 is the PARADA transition.
- Frame length is 10*CICLOS_BIT cycles, counted from the first INICIO cycle.
- fin_o is asserted for exactly the first REPOSO cycle after PARADA. In that cycle listo_o=1 and a new transfer may be accepted, so there is a minimum gap of 1 idle cycle between frames.
- serie_o and all outputs are registered; no combinational path from inputs to outputs.
- palabra_o holds its value until the next transfer or reset.
- Reset asserted mid-frame: at that edge the block aborts to the reset values above, with no fin_o pulse.

Optional Feature:
- Macro INYECCION_ERROR_EN.
- Defined:
  - Port mascara_error_i exists.
  - At transfer, palabra_o loads codeword ^ mascara_error_i; the serial frame carries the corrupted word.
  - The mask is sampled only on the transfer edge.
- Undefined:
  - Port is absent.
  - palabra_o is always the clean codeword.

Test Plan:
1. CICLOS_BIT=4, dato_i=4'b1100, valido_i pulse → palabra_o=8'hE1.
   - serie_o: 0 for 4 cycles, then 1,0,0,0,0,1,1,1 (4 cycles each), then 1 for 4 cycles.
   - activo_o high for 40 cycles; fin_o single pulse on cycle 41.
2. Encoding sweep:
   - dato 4'b0000 → 8'h00.
   - dato 4'b1111 → 8'hFF.
   - dato 4'b0001 → 8'h87.
   - All 16 values checked against a reference model; each codeword has an even number of ones.
3. valido_i held high with dato_i changing mid-frame → listo_o=0 during the frame and palabra_o unchanged. The next word is accepted on the fin_o cycle; frames run back-to-back with one idle cycle.
4. rst_n low for one edge during DATOS bit 3 → next cycle serie_o=1, listo_o=1, activo_o=0, palabra_o=8'h00, no fin_o pulse.
5. CICLOS_BIT=1, dato 4'b1100 → 10-cycle frame, bits exactly one cycle each.
6. INYECCION_ERROR_EN, dato 4'b1100:
   - mascara 8'h04 → palabra_o=8'hE5.
   - mascara 8'h60 → palabra_o=8'h81.
   - Serial frame matches palabra_o in both cases.
